// File: rtl/execute_mul_pipe.sv
// execute_mul_pipe: pipelined RV M-extension multiply execute unit.
//   Pops issue packs from the mul issue FIFO. Computes mul/mulh/mulhsu/mulhu
//   over STAGES register stages. Drives the mul writeback port and an early
//   wakeup/bypass feedback packet.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   issue_mul_fifo_data_out/_valid    FIFO head pack and its valid
//   issue_mul_fifo_pop                dequeue FIFO head this cycle
//   mul_wb_port_data_in/_we           writeback pack and write strobe
//   mul_wb_port_flush                 clear writeback port (rst | flush)
//   mul_wb_port_full                  writeback port backpressure
//   mul_execute_channel_feedback_pack wakeup/bypass value
//   commit_feedback_pack              commit feedback; flush source
// Value fields in the packs are VAL_W (64) bits wide. XLEN selects how many
// of those bits take part in the arithmetic; rd_value is zero-extended.

package execute_mul_pkg;
   localparam int VAL_W = 64;
   localparam int ROB_W = 7;
   localparam int PHY_W = 6;

   typedef enum logic [1:0] {
      MUL_OP_MUL, MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU
   } mul_op_t;

   typedef enum logic [3:0] {
      EXC_INSTR_MISALIGNED    = 4'd0,
      EXC_INSTR_ACCESS_FAULT  = 4'd1,
      EXC_ILLEGAL_INSTRUCTION = 4'd2,
      EXC_BREAKPOINT          = 4'd3
   } exception_id_t;

   typedef struct packed {
      logic             enable;
      logic             valid;
      logic [ROB_W-1:0] rob_id;
      logic [31:0]      pc;
      logic             has_exception;
      exception_id_t    exception_id;
      logic [31:0]      exception_value;
      logic [4:0]       rd;
      logic             rd_enable;
      logic             need_rename;
      logic [PHY_W-1:0] rd_phy;
      mul_op_t          op;
      logic [VAL_W-1:0] src1_value;
      logic [VAL_W-1:0] src2_value;
   } issue_execute_pack_t;

   typedef struct packed {
      logic             enable;
      logic             valid;
      logic [ROB_W-1:0] rob_id;
      logic [31:0]      pc;
      logic             has_exception;
      exception_id_t    exception_id;
      logic [31:0]      exception_value;
      logic [4:0]       rd;
      logic             rd_enable;
      logic             need_rename;
      logic [PHY_W-1:0] rd_phy;
      logic [VAL_W-1:0] rd_value;
   } execute_wb_pack_t;

   typedef struct packed {
      logic             enable;
      logic [PHY_W-1:0] phy_id;
      logic [VAL_W-1:0] value;
   } execute_feedback_channel_t;

   typedef struct packed {
      logic enable;
      logic flush;
   } commit_feedback_pack_t;
endpackage

module execute_mul_pipe
   import execute_mul_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int STAGES = 3
)(
   input  logic                      clk,
   input  logic                      rst,
   input  issue_execute_pack_t       issue_mul_fifo_data_out,
   input  logic                      issue_mul_fifo_data_out_valid,
   output logic                      issue_mul_fifo_pop,
   output execute_wb_pack_t          mul_wb_port_data_in,
   output logic                      mul_wb_port_we,
   output logic                      mul_wb_port_flush,
   input  logic                      mul_wb_port_full,
   output execute_feedback_channel_t mul_execute_channel_feedback_pack,
   input  commit_feedback_pack_t     commit_feedback_pack
);
   localparam int PW   = 2*XLEN + 2;
   localparam int LAST = STAGES - 1;

   logic [STAGES-1:0]    r_vld;
   issue_execute_pack_t  r_pack [STAGES];
   issue_execute_pack_t  w_tail;
   logic                 w_flush, w_stall, w_pop, w_we;
   logic signed [XLEN:0] w_a, w_b;
   logic signed [PW-1:0] w_prod0, w_prod;
   logic [XLEN-1:0]      w_result;
   logic                 w_a_sgn, w_b_sgn;
   logic                 w_unused;

   assign w_flush = commit_feedback_pack.enable & commit_feedback_pack.flush;
   // Stall is global: a full port freezes every stage, bubbles included.
   assign w_stall = r_vld[LAST] & mul_wb_port_full;
   assign w_pop   = issue_mul_fifo_data_out_valid & ~w_stall & ~w_flush & ~rst;
   assign w_we    = r_vld[LAST] & ~mul_wb_port_full & ~w_flush & ~rst;

   assign issue_mul_fifo_pop = w_pop;
   assign mul_wb_port_we     = w_we;
   assign mul_wb_port_flush  = rst | w_flush;

   // Valid shift register; flush and reset win over stall.
   always_ff @(posedge clk) begin
      if (rst || w_flush) begin
         r_vld <= '0;
      end else if (!w_stall) begin
         r_vld[0] <= w_pop;
         for (int k = 1; k < STAGES; k++) r_vld[k] <= r_vld[k-1];
      end
   end

   // Pack payload needs no reset; it is qualified by r_vld.
   always_ff @(posedge clk) begin
      if (!w_stall) begin
         if (w_pop) r_pack[0] <= issue_mul_fifo_data_out;
         for (int k = 1; k < STAGES; k++) r_pack[k] <= r_pack[k-1];
      end
   end

   // XLEN+1-bit operand extension lets one signed multiplier cover all
   // four signedness combinations.
   assign w_a_sgn = (r_pack[0].op == MUL_OP_MULH) || (r_pack[0].op == MUL_OP_MULHSU);
   assign w_b_sgn = (r_pack[0].op == MUL_OP_MULH);
   assign w_a     = {w_a_sgn & r_pack[0].src1_value[XLEN-1], r_pack[0].src1_value[XLEN-1:0]};
   assign w_b     = {w_b_sgn & r_pack[0].src2_value[XLEN-1], r_pack[0].src2_value[XLEN-1:0]};
   assign w_prod0 = PW'(w_a) * PW'(w_b);

   // The product is formed between s[0] and s[1] and then carried along.
   // A single-stage pipe multiplies combinationally out of s[0].
   if (STAGES == 1) begin : g_comb
      assign w_prod = w_prod0;
   end else begin : g_pipe
      logic signed [PW-1:0] r_prod [1:STAGES-1];
      always_ff @(posedge clk) begin
         if (!w_stall) begin
            r_prod[1] <= w_prod0;
            for (int k = 2; k < STAGES; k++) r_prod[k] <= r_prod[k-1];
         end
      end
      assign w_prod = r_prod[STAGES-1];
   end

   assign w_tail   = r_pack[LAST];
   assign w_result = (w_tail.op == MUL_OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

   always_comb begin
      mul_wb_port_data_in = '0;
      if (r_vld[LAST]) begin
         mul_wb_port_data_in.enable          = w_tail.enable;
         mul_wb_port_data_in.valid           = w_tail.valid;
         mul_wb_port_data_in.rob_id          = w_tail.rob_id;
         mul_wb_port_data_in.pc              = w_tail.pc;
         mul_wb_port_data_in.has_exception   = w_tail.has_exception;
         mul_wb_port_data_in.exception_id    = w_tail.exception_id;
         mul_wb_port_data_in.exception_value = w_tail.exception_value;
         mul_wb_port_data_in.rd              = w_tail.rd;
         mul_wb_port_data_in.rd_enable       = w_tail.rd_enable;
         mul_wb_port_data_in.need_rename     = w_tail.need_rename;
         mul_wb_port_data_in.rd_phy          = w_tail.rd_phy;
         if (w_tail.valid && !w_tail.has_exception)
            mul_wb_port_data_in.rd_value = VAL_W'(w_result);
      end
   end

   // Wakeup only for real, renamed destinations that are actually written.
   always_comb begin
      mul_execute_channel_feedback_pack = '0;
      if (w_we && w_tail.valid && !w_tail.has_exception && w_tail.rd_enable && w_tail.need_rename) begin
         mul_execute_channel_feedback_pack.enable = 1'b1;
         mul_execute_channel_feedback_pack.phy_id = w_tail.rd_phy;
         mul_execute_channel_feedback_pack.value  = mul_wb_port_data_in.rd_value;
      end
   end

   // Operand copies in the last stage and the product guard bits are never
   // consumed.
   assign w_unused = ^{w_tail.src1_value, w_tail.src2_value, w_prod[PW-1:2*XLEN]};

endmodule

// File: tb/tb_execute_mul_pipe.sv
// Scoreboard bench for execute_mul_pipe (XLEN=32, STAGES=3). The stimulus
// side models the issue FIFO. On each pop, it moves the hand-computed
// expectation into the scoreboard. A negedge monitor pops and compares on
// every writeback.
module tb_execute_mul_pipe;
   import execute_mul_pkg::*;
   localparam int XLEN   = 32;
   localparam int STAGES = 3;

   logic                      clk = 1'b0;
   logic                      rst;
   issue_execute_pack_t       in_pack;
   logic                      in_valid;
   logic                      pop;
   execute_wb_pack_t          wb;
   logic                      we;
   logic                      wb_flush;
   logic                      full;
   execute_feedback_channel_t fb;
   commit_feedback_pack_t     cfb;

   typedef struct {
      logic [6:0]    rob;
      logic [63:0]   val;
      logic          vld;
      logic          exc;
      exception_id_t eid;
      logic          fb_en;
      logic [5:0]    phy;
      int            pop_cyc;
      bit            chk_lat;
   } exp_t;

   issue_execute_pack_t fifo[$];
   exp_t pend[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   pops   = 0;
   bit   lat_on = 1'b1;

   execute_mul_pipe #(.XLEN(XLEN), .STAGES(STAGES)) dut (
      .clk                               (clk),
      .rst                               (rst),
      .issue_mul_fifo_data_out           (in_pack),
      .issue_mul_fifo_data_out_valid     (in_valid),
      .issue_mul_fifo_pop                (pop),
      .mul_wb_port_data_in               (wb),
      .mul_wb_port_we                    (we),
      .mul_wb_port_flush                 (wb_flush),
      .mul_wb_port_full                  (full),
      .mul_execute_channel_feedback_pack (fb),
      .commit_feedback_pack              (cfb)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic refresh();
      in_valid = (fifo.size() != 0);
      in_pack  = (fifo.size() != 0) ? fifo[0] : '0;
   endtask

   task automatic issue(input mul_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [6:0] rob, input logic [5:0] phy, input logic rd_en,
                        input logic nr, input logic v, input logic exc,
                        input exception_id_t eid, input logic [63:0] expv);
      issue_execute_pack_t p;
      exp_t e;
      p = '0;
      p.enable = 1'b1; p.valid = v; p.rob_id = rob; p.pc = {23'd0, rob, 2'b00};
      p.has_exception = exc; p.exception_id = eid; p.rd = 5'd3;
      p.rd_enable = rd_en; p.need_rename = nr; p.rd_phy = phy; p.op = op;
      p.src1_value = {32'd0, a}; p.src2_value = {32'd0, b};
      fifo.push_back(p);
      e.rob = rob; e.val = expv; e.vld = v; e.exc = exc; e.eid = eid; e.phy = phy;
      e.fb_en = v & ~exc & rd_en & nr; e.pop_cyc = 0; e.chk_lat = lat_on;
      pend.push_back(e);
      refresh();
   endtask

   // One clock: sample pop before the edge, retire the FIFO head after it.
   task automatic cycle();
      bit   popped;
      int   pc;
      exp_t e;
      @(negedge clk);
      popped = pop;
      pc     = cyc;
      @(posedge clk);
      #1;
      if (popped) begin
         if (fifo.size() == 0 || pend.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_pop actual=1 required=0");
         end else begin
            in_pack   = fifo.pop_front();
            e         = pend.pop_front();
            e.pop_cyc = pc;
            sb.push_back(e);
            pops++;
         end
      end
      refresh();
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Monitor: every writeback must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t m;
      if (!rst && we === 1'b1) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_wb actual_rob=%0h required=none", wb.rob_id);
         end else begin
            m = sb.pop_front();
            chk("wb_rob",      64'(wb.rob_id), 64'(m.rob));
            chk("wb_rd_value", wb.rd_value, m.val);
            chk("wb_valid",    64'(wb.valid), 64'(m.vld));
            chk("wb_exc",      64'(wb.has_exception), 64'(m.exc));
            chk("wb_exc_id",   64'(wb.exception_id), 64'(m.eid));
            chk("fb_enable",   64'(fb.enable), 64'(m.fb_en));
            chk("fb_phy",      64'(fb.phy_id), m.fb_en ? 64'(m.phy) : 64'd0);
            chk("fb_value",    fb.value, m.fb_en ? m.val : 64'd0);
            if (m.chk_lat) chk("latency", 64'(cyc - m.pop_cyc), 64'(STAGES));
         end
      end
   end

   initial begin
      rst  = 1'b1;
      full = 1'b0;
      cfb  = '0;
      refresh();
      @(posedge clk);
      #1;
      // A pending head must not be popped while in reset.
      issue(MUL_OP_MUL, 32'd1, 32'd1, 7'd0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0, EXC_INSTR_MISALIGNED, 64'd1);
      #1;
      chk("rst_flush", 64'(wb_flush), 64'd1);
      chk("rst_pop",   64'(pop), 64'd0);
      chk("rst_we",    64'(we), 64'd0);
      chk("rst_fb",    64'(fb.enable), 64'd0);
      fifo.delete();
      pend.delete();
      refresh();
      cycle();
      rst = 1'b0;
      #1;
      chk("idle_flush", 64'(wb_flush), 64'd0);
      chk("idle_pop",   64'(pop), 64'd0);
      chk("idle_we",    64'(we), 64'd0);
      chk("idle_fb",    64'(fb.enable), 64'd0);
      run(2);

      // Basic mul with wakeup.
      issue(MUL_OP_MUL, 32'd12, 32'd6, 7'd1, 6'd10, 1'b1, 1'b1, 1'b1, 1'b0, EXC_INSTR_MISALIGNED, 64'd72);
      run(6);

      // Back-to-back high-half ops.
      begin
         int p0;
         p0 = pops;
         issue(MUL_OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 7'd2, 6'd11, 1'b1, 1'b1, 1'b1, 1'b0, EXC_INSTR_MISALIGNED, 64'h00000000);
         issue(MUL_OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 7'd3, 6'd12, 1'b1, 1'b1, 1'b1, 1'b0, EXC_INSTR_MISALIGNED, 64'hFFFFFFFE);
         issue(MUL_OP_MULHSU, 32'hFFFFFFFF, 32'd2,        7'd4, 6'd13, 1'b1, 1'b1, 1'b1, 1'b0, EXC_INSTR_MISALIGNED, 64'hFFFFFFFF);
         run(3);
         chk("b2b_pops", 64'(pops - p0), 64'd3);
         run(5);
      end

      // More signedness corners; the last op has rd_enable=0 and gives no wakeup.
      issue(MUL_OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 7'd5, 6'd14, 1'b1, 1'b1, 1'b1, 1'b0, EXC_INSTR_MISALIGNED, 64'h00000001);
      issue(MUL_OP_MULHSU, 32'd2,        32'hFFFFFFFF, 7'd6, 6'd15, 1'b1, 1'b1, 1'b1, 1'b0, EXC_INSTR_MISALIGNED, 64'h00000001);
      issue(MUL_OP_MULH,   32'h80000000, 32'h80000000, 7'd7, 6'd16, 1'b1, 1'b1, 1'b1, 1'b0, EXC_INSTR_MISALIGNED, 64'h40000000);
      issue(MUL_OP_MULHU,  32'h80000000, 32'd2,        7'd8, 6'd17, 1'b1, 1'b1, 1'b1, 1'b0, EXC_INSTR_MISALIGNED, 64'h00000001);
      issue(MUL_OP_MUL,    32'h12345678, 32'h10,       7'd9, 6'd18, 1'b0, 1'b1, 1'b1, 1'b0, EXC_INSTR_MISALIGNED, 64'h23456780);
      run(10);

      // Exceptional, invalid pack still completes, with a zero result and no wakeup.
      issue(MUL_OP_MUL, 32'd5, 32'd7, 7'd10, 6'd19, 1'b1, 1'b1, 1'b0, 1'b1, EXC_ILLEGAL_INSTRUCTION, 64'd0);
      run(6);

      // Backpressure for 2 cycles once the first op reaches the last stage.
      lat_on = 1'b0;
      issue(MUL_OP_MUL, 32'd3, 32'd3, 7'd20, 6'd20, 1'b1, 1'b1, 1'b1, 1'b0, EXC_INSTR_MISALIGNED, 64'd9);
      issue(MUL_OP_MUL, 32'd4, 32'd4, 7'd21, 6'd21, 1'b1, 1'b1, 1'b1, 1'b0, EXC_INSTR_MISALIGNED, 64'd16);
      issue(MUL_OP_MUL, 32'd5, 32'd5, 7'd22, 6'd22, 1'b1, 1'b1, 1'b1, 1'b0, EXC_INSTR_MISALIGNED, 64'd25);
      run(3);
      full = 1'b1;
      issue(MUL_OP_MUL, 32'd6, 32'd6, 7'd23, 6'd23, 1'b1, 1'b1, 1'b1, 1'b0, EXC_INSTR_MISALIGNED, 64'd36);
      #1;
      chk("stall1_we",  64'(we), 64'd0);
      chk("stall1_pop", 64'(pop), 64'd0);
      cycle();
      chk("stall2_we",  64'(we), 64'd0);
      chk("stall2_pop", 64'(pop), 64'd0);
      cycle();
      full = 1'b0;
      #1;
      chk("release_we",  64'(we), 64'd1);
      chk("release_pop", 64'(pop), 64'd1);
      run(8);
      lat_on = 1'b1;

      // Flush with two ops in flight (one in the last stage, one in the middle stage).
      issue(MUL_OP_MUL, 32'd7, 32'd7, 7'd30, 6'd30, 1'b1, 1'b1, 1'b1, 1'b0, EXC_INSTR_MISALIGNED, 64'd49);
      issue(MUL_OP_MUL, 32'd8, 32'd8, 7'd31, 6'd31, 1'b1, 1'b1, 1'b1, 1'b0, EXC_INSTR_MISALIGNED, 64'd64);
      run(3);
      cfb.enable = 1'b1;
      cfb.flush  = 1'b1;
      issue(MUL_OP_MUL, 32'd9, 32'd9, 7'd32, 6'd32, 1'b1, 1'b1, 1'b1, 1'b0, EXC_INSTR_MISALIGNED, 64'd81);
      sb.delete();
      #1;
      chk("flush_port", 64'(wb_flush), 64'd1);
      chk("flush_pop",  64'(pop), 64'd0);
      chk("flush_we",   64'(we), 64'd0);
      chk("flush_fb",   64'(fb.enable), 64'd0);
      cycle();
      cfb = '0;
      run(8);

      run(4);
      chk("sb_empty",   64'(sb.size()), 64'd0);
      chk("fifo_empty", 64'(fifo.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard bound on total simulation time.
   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
